wav_xfade_sel: RTL and testbench

Parametrised waveform selector: the N-channel, crossfading successor to the four-way sine/triangle/saw/square selector. It sits between the oscillator waveform generators and the output DAC/mixer path. It takes N packed W-bit waveform streams and steps the selection with next/prev buttons or a direct load. Each selection change is a linear crossfade over 2^XF_LOG2 sample strobes, which avoids audible clicks.

---
 rtl/wav_xfade_sel_if.sv | 24 ++
 rtl/wav_xfade_sel.sv | 108 ++++++++++
 tb/tb_wav_xfade_sel.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/wav_xfade_sel_if.sv
// wav_xfade_sel_if: waveform selector bus (channel data, controls, selected output).
interface wav_xfade_sel_if #(
  parameter int W = 8,
  parameter int N = 4
);
  localparam int SW = $clog2(N);
  logic [N*W-1:0] wav_in;
  logic           sample_en;
  logic           next_in;
  logic           prev_in;
  logic           sel_load;
  logic [SW-1:0]  sel_val;
  logic [W-1:0]   wav;
  logic [SW-1:0]  sel;
  logic           busy;
  modport master (
    output wav_in, sample_en, next_in, prev_in, sel_load, sel_val,
    input  wav, sel, busy
  );
  modport slave (
    input  wav_in, sample_en, next_in, prev_in, sel_load, sel_val,
    output wav, sel, busy
  );
endinterface

// File: rtl/wav_xfade_sel.sv
// wav_xfade_sel: N-channel waveform selector with linear crossfade on selection change.
module wav_xfade_sel #(
  parameter int W       = 8,
  parameter int N       = 4,
  parameter int XF_LOG2 = 4
) (
  input  logic           clk,
  input  logic           rst,
  wav_xfade_sel_if.slave bus
);
  localparam int SW = $clog2(N);
  localparam int K  = XF_LOG2;
  localparam int CW = (K > 0) ? K : 1;
  typedef enum logic {IDLE, FADE} state_t;
  state_t        state, state_d;
  logic [SW-1:0] sel, sel_d, src, src_d, pend, pend_d, base, req, inc, dec;
  logic          pend_v, pend_v_d, busy, busy_d, next_r, prev_r, rise_n, rise_p, req_v;
  logic [CW-1:0] cnt, cnt_d;
  logic [W-1:0]  wav, wav_d, ch_sel, ch_src, blend;
  logic [K:0]    wsrc;
  logic [W+K-1:0] acc;
  logic [W-1:0]  ch [N];
  for (genvar k = 0; k < N; k++) begin : g_ch
    assign ch[k] = bus.wav_in[k*W +: W];
  end
  assign rise_n = bus.next_in & ~next_r;
  assign rise_p = bus.prev_in & ~prev_r;
  // Steps chain off the pending target so repeated presses during a fade accumulate.
  assign base  = pend_v ? pend : sel;
  assign inc   = (base == SW'(N-1)) ? '0 : base + SW'(1);
  assign dec   = (base == '0) ? SW'(N-1) : base - SW'(1);
  assign req_v = bus.sel_load ? (int'(bus.sel_val) < N) : (rise_n ^ rise_p);
  assign req   = bus.sel_load ? bus.sel_val : rise_n ? inc : dec;
  assign ch_sel = ch[sel];
  assign ch_src = ch[src];
  // Weights sum to 2^K, so the sum stays within W+K bits and the shift truncates.
  assign wsrc  = (K+1)'(2**K) - (K+1)'(cnt);
  assign acc   = (W+K)'(ch_src) * (W+K)'(wsrc) + (W+K)'(ch_sel) * (W+K)'(cnt);
  assign blend = W'(acc >> K);
  always_comb begin
    state_d  = state;
    sel_d    = sel;
    src_d    = src;
    cnt_d    = cnt;
    busy_d   = busy;
    pend_d   = pend;
    pend_v_d = pend_v;
    wav_d    = ch_sel;
    if (state == IDLE) begin
      if (req_v && req != sel) begin
        sel_d = req;
        if (K > 0) begin
          src_d   = sel;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = FADE;
        end
      end
    end else begin
      wav_d = blend;
      if (req_v) begin
        pend_d   = req;
        pend_v_d = req != sel;
      end
      if (bus.sample_en) begin
        cnt_d = cnt + CW'(1);
        if (&cnt) begin
          if (pend_v_d) begin
            src_d    = sel;
            sel_d    = pend_d;
            pend_v_d = 1'b0;
          end else begin
            busy_d  = 1'b0;
            state_d = IDLE;
          end
        end
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      sel    <= '0;
      src    <= '0;
      cnt    <= '0;
      busy   <= 1'b0;
      pend   <= '0;
      pend_v <= 1'b0;
      wav    <= '0;
      next_r <= 1'b0;
      prev_r <= 1'b0;
    end else begin
      state  <= state_d;
      sel    <= sel_d;
      src    <= src_d;
      cnt    <= cnt_d;
      busy   <= busy_d;
      pend   <= pend_d;
      pend_v <= pend_v_d;
      wav    <= wav_d;
      next_r <= bus.next_in;
      prev_r <= bus.prev_in;
    end
  end
  assign bus.wav  = wav;
  assign bus.sel  = sel;
  assign bus.busy = busy;
endmodule

// File: tb/tb_wav_xfade_sel.sv
// tb_wav_xfade_sel: scoreboard bench for three selector variants (N4/K2, N3/K2, N4/K0).
module tb_wav_xfade_sel;
  logic clk = 1'b0, rst = 1'b1;
  logic se = 1'b1, nx = 1'b0, pv = 1'b0, ld = 1'b0;
  logic [1:0] lv = '0;
  logic [31:0] chans = {8'h40, 8'hFF, 8'h80, 8'h00};
  string scen = "reset";
  int n_chk = 0, n_err = 0;
  typedef struct {string tag; int d; int w; int s; int b;} exp_t;
  exp_t q[$];
  exp_t e;
  logic [7:0] gw;
  logic [1:0] gs;
  logic gb;
  always #5 clk = ~clk;
  wav_xfade_sel_if #(.W(8), .N(4)) m_if ();
  wav_xfade_sel_if #(.W(8), .N(3)) n_if ();
  wav_xfade_sel_if #(.W(8), .N(4)) z_if ();
  assign m_if.wav_in = chans;
  assign n_if.wav_in = chans[23:0];
  assign z_if.wav_in = chans;
  assign {m_if.sample_en, m_if.next_in, m_if.prev_in, m_if.sel_load, m_if.sel_val} = {se, nx, pv, ld, lv};
  assign {n_if.sample_en, n_if.next_in, n_if.prev_in, n_if.sel_load, n_if.sel_val} = {se, nx, pv, ld, lv};
  assign {z_if.sample_en, z_if.next_in, z_if.prev_in, z_if.sel_load, z_if.sel_val} = {se, nx, pv, ld, lv};
  wav_xfade_sel #(.W(8), .N(4), .XF_LOG2(2)) u_main (.clk(clk), .rst(rst), .bus(m_if.slave));
  wav_xfade_sel #(.W(8), .N(3), .XF_LOG2(2)) u_n3   (.clk(clk), .rst(rst), .bus(n_if.slave));
  wav_xfade_sel #(.W(8), .N(4), .XF_LOG2(0)) u_k0   (.clk(clk), .rst(rst), .bus(z_if.slave));
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  // Expectation for the state after the coming rising edge; w < 0 skips the wav check.
  task automatic cyc(input int d, input int w, input int s, input int b);
    q.push_back('{scen, d, w, s, b});
    @(negedge clk);
  endtask
  task automatic rst_all(input int d);
    rst = 1'b1;
    {nx, pv, ld, se} = 4'b0001;
    cyc(d, 'h00, 0, 0);
    rst = 1'b0;
  endtask
  always @(negedge clk) begin
    if (q.size() > 0) begin
      e  = q.pop_front();
      gw = (e.d == 0) ? m_if.wav : (e.d == 1) ? n_if.wav : z_if.wav;
      gs = (e.d == 0) ? m_if.sel : (e.d == 1) ? n_if.sel : z_if.sel;
      gb = (e.d == 0) ? m_if.busy : (e.d == 1) ? n_if.busy : z_if.busy;
      if (e.w >= 0) check({e.tag, ".wav"}, 32'(gw), 32'(e.w));
      check({e.tag, ".sel"}, 32'(gs), 32'(e.s));
      check({e.tag, ".busy"}, 32'(gb), 32'(e.b));
    end
  end
  initial begin
    rst_all(0);
    cyc(0, 'h00, 0, 0);
    chans[7:0] = 8'h33;
    cyc(0, 'h33, 0, 0);
    chans[7:0] = 8'h00;
    cyc(0, 'h00, 0, 0);
    scen = "next";
    rst_all(0);
    nx = 1; cyc(0, 'h00, 1, 1);
    nx = 0; cyc(0, 'h00, 1, 1);
    cyc(0, 'h20, 1, 1);
    cyc(0, 'h40, 1, 1);
    cyc(0, 'h60, 1, 0);
    cyc(0, 'h80, 1, 0);
    scen = "prev_wrap_gap";
    rst_all(0);
    pv = 1; cyc(0, 'h00, 3, 1);
    pv = 0; cyc(0, 'h00, 3, 1);
    se = 0; cyc(0, 'h10, 3, 1);
    se = 1; cyc(0, 'h10, 3, 1);
    cyc(0, 'h20, 3, 1);
    cyc(0, 'h30, 3, 0);
    cyc(0, 'h40, 3, 0);
    scen = "chain";
    rst_all(0);
    nx = 1; cyc(0, 'h00, 1, 1);
    nx = 0; cyc(0, 'h00, 1, 1);
    nx = 1; cyc(0, 'h20, 1, 1);
    nx = 0; cyc(0, 'h40, 1, 1);
    cyc(0, 'h60, 2, 1);
    cyc(0, 'h80, 2, 1);
    cyc(0, 'h9F, 2, 1);
    cyc(0, 'hBF, 2, 1);
    cyc(0, 'hDF, 2, 0);
    cyc(0, 'hFF, 2, 0);
    scen = "cancel";
    rst_all(0);
    nx = 1; cyc(0, 'h00, 1, 1);
    nx = 0; cyc(0, 'h00, 1, 1);
    nx = 1; cyc(0, 'h20, 1, 1);
    nx = 0; pv = 1; cyc(0, 'h40, 1, 1);
    pv = 0; cyc(0, 'h60, 1, 0);
    cyc(0, 'h80, 1, 0);
    scen = "collide_load";
    rst_all(0);
    nx = 1; pv = 1; cyc(0, 'h00, 0, 0);
    nx = 0; pv = 0; cyc(0, 'h00, 0, 0);
    ld = 1; lv = 0; cyc(0, 'h00, 0, 0);
    ld = 0; cyc(0, 'h00, 0, 0);
    ld = 1; lv = 2; nx = 1; cyc(0, 'h00, 2, 1);
    ld = 0; nx = 0; cyc(0, 'h00, 2, 1);
    cyc(0, 'h3F, 2, 1);
    cyc(0, 'h7F, 2, 1);
    cyc(0, 'hBF, 2, 0);
    cyc(0, 'hFF, 2, 0);
    scen = "reset_mid";
    rst_all(0);
    nx = 1; cyc(0, 'h00, 1, 1);
    nx = 0; cyc(0, 'h00, 1, 1);
    cyc(0, 'h20, 1, 1);
    rst = 1; nx = 1; cyc(0, 'h00, 0, 0);
    rst = 0; cyc(0, 'h00, 1, 1);
    cyc(0, 'h00, 1, 1);
    nx = 0; cyc(0, 'h20, 1, 1);
    scen = "n3";
    rst_all(1);
    ld = 1; lv = 3; cyc(1, 'h00, 0, 0);
    ld = 0; cyc(1, 'h00, 0, 0);
    pv = 1; cyc(1, 'h00, 2, 1);
    pv = 0; cyc(1, 'h00, 2, 1);
    cyc(1, 'h3F, 2, 1);
    cyc(1, 'h7F, 2, 1);
    cyc(1, 'hBF, 2, 0);
    cyc(1, 'hFF, 2, 0);
    scen = "k0";
    rst_all(2);
    nx = 1; cyc(2, 'h00, 1, 0);
    nx = 0; cyc(2, 'h80, 1, 0);
    cyc(2, 'h80, 1, 0);
    pv = 1; cyc(2, 'h80, 0, 0);
    pv = 0; cyc(2, 'h00, 0, 0);
    #1;
    check("drain", 32'(q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
